// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the ALU request scheduler.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned ALU_OPW = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic [ALU_OPW-1:0] opcode;
    logic [ALU_W-1:0]   op1;
    logic [ALU_W-1:0]   op2;
  } req_fields_t;

  // Extract requester idx's opcode/operands from zero-padded packed buses.
  function automatic req_fields_t unpack_req(
    input logic [MAX_REQ*ALU_OPW-1:0] opc_bus,
    input logic [MAX_REQ*ALU_W-1:0]   op1_bus,
    input logic [MAX_REQ*ALU_W-1:0]   op2_bus,
    input int unsigned                idx
  );
    req_fields_t f;
    f.opcode = opc_bus[idx*ALU_OPW +: ALU_OPW];
    f.op1    = op1_bus[idx*ALU_W +: ALU_W];
    f.op2    = op2_bus[idx*ALU_W +: ALU_W];
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic        found;
  int unsigned j;

  // Scan NREQ positions starting at ptr; wrap at NREQ, not at 2**IDW.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NREQ requesters, one op in flight.
module alu_sched
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned W       = 4,
  parameter int unsigned OPW     = 3,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*OPW-1:0] req_opcode,
  input  logic [NREQ*W-1:0]  req_op1,
  input  logic [NREQ*W-1:0]  req_op2,
  output logic [OPW-1:0]     alu_opcode,
  output logic [W-1:0]       alu_op1,
  output logic [W-1:0]       alu_op2,
  input  logic [W-1:0]       alu_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               busy
);

  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [IDW-1:0]             rr_ptr;
  logic [NREQ-1:0]            gnt;
  logic [IDW-1:0]             gnt_idx;
  logic [MAX_REQ*ALU_OPW-1:0] opc_pad;
  logic [MAX_REQ*ALU_W-1:0]   op1_pad;
  logic [MAX_REQ*ALU_W-1:0]   op2_pad;
  req_fields_t                sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Pad the request buses to the package maximum and pick the granted requester's fields.
  always_comb begin
    opc_pad = '0;
    op1_pad = '0;
    op2_pad = '0;
    opc_pad[NREQ*OPW-1:0] = req_opcode;
    op1_pad[NREQ*W-1:0]   = req_op1;
    op2_pad[NREQ*W-1:0]   = req_op2;
    sel = unpack_req(opc_pad, op1_pad, op2_pad, 32'(gnt_idx));
  end

  // Grant is only visible in IDLE and never while reset is asserted.
  assign req_ready = (rstn && state == IDLE) ? gnt : '0;

  // Control FSM with registered ALU drive, response channel and busy flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            alu_opcode <= sel.opcode;
            alu_op1    <= sel.op1;
            alu_op2    <= sel.op2;
            rsp_id     <= gnt_idx;
            cnt        <= CW'(ALU_LAT);
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_data  <= alu_res;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with three configurations.
module tb_alu_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, rstn1;
  int unsigned pass_cnt = 0;
  int unsigned total = 0;
  int unsigned cyc = 0;
  int unsigned acc1, acc2;

  always @(posedge clk) cyc++;

  // dut0: NREQ=2, ALU_LAT=1
  logic [1:0] v0, rdy0;
  logic [5:0] opc0;
  logic [7:0] a0, b0;
  logic [2:0] aopc0;
  logic [3:0] aa0, ab0, res0, rd0;
  logic       rv0, rr0, rid0, busy0;

  // dut1: NREQ=2, ALU_LAT=3
  logic [1:0] v1, rdy1;
  logic [5:0] opc1;
  logic [7:0] a1, b1;
  logic [2:0] aopc1;
  logic [3:0] aa1, ab1, res1, rd1;
  logic       rv1, rr1, rid1, busy1;

  // dut2: NREQ=3, ALU_LAT=2
  logic [2:0]  v2, rdy2;
  logic [8:0]  opc2;
  logic [11:0] a2, b2;
  logic [2:0]  aopc2;
  logic [3:0]  aa2, ab2, res2, rd2;
  logic        rv2, rr2, busy2;
  logic [1:0]  rid2;

  alu_sched #(.NREQ(2), .W(4), .OPW(3), .ALU_LAT(1), .IDW(1)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(v0), .req_ready(rdy0), .req_opcode(opc0),
    .req_op1(a0), .req_op2(b0), .alu_opcode(aopc0), .alu_op1(aa0), .alu_op2(ab0),
    .alu_res(res0), .rsp_valid(rv0), .rsp_ready(rr0), .rsp_id(rid0), .rsp_data(rd0),
    .busy(busy0));

  alu_sched #(.NREQ(2), .W(4), .OPW(3), .ALU_LAT(3), .IDW(1)) dut1 (
    .clk(clk), .rstn(rstn1), .req_valid(v1), .req_ready(rdy1), .req_opcode(opc1),
    .req_op1(a1), .req_op2(b1), .alu_opcode(aopc1), .alu_op1(aa1), .alu_op2(ab1),
    .alu_res(res1), .rsp_valid(rv1), .rsp_ready(rr1), .rsp_id(rid1), .rsp_data(rd1),
    .busy(busy1));

  alu_sched #(.NREQ(3), .W(4), .OPW(3), .ALU_LAT(2), .IDW(2)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(v2), .req_ready(rdy2), .req_opcode(opc2),
    .req_op1(a2), .req_op2(b2), .alu_opcode(aopc2), .alu_op1(aa2), .alu_op2(ab2),
    .alu_res(res2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(rid2), .rsp_data(rd2),
    .busy(busy2));

  // ALU stubs: (op1+op2) mod 16, valid ALU_LAT edges after the inputs change
  logic [3:0] p1a, p1b, p2a;
  assign res0 = aa0 + ab0;
  always @(posedge clk) begin
    p1a <= aa1 + ab1;
    p1b <= p1a;
    p2a <= aa2 + ab2;
  end
  assign res1 = p1b;
  assign res2 = p2a;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; rstn1 = 1'b0;
    v0 = 2'b11; opc0 = 6'o77; a0 = 8'hFF; b0 = 8'hFF; rr0 = 1'b1;
    v1 = 2'b00; opc1 = '0; a1 = '0; b1 = '0; rr1 = 1'b1;
    v2 = 3'b000; opc2 = '0; a2 = '0; b2 = '0; rr2 = 1'b1;
    #1;
    total++; if (rdy0 !== 2'b00) $display("FAIL reset_ready: got %b want 00", rdy0); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rdy0 !== 2'b00) $display("FAIL reset_ready_clk: got %b want 00", rdy0); else pass_cnt++;
    total++; if (rv0 !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rv0); else pass_cnt++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else pass_cnt++;
    total++; if (aa0 !== 4'h0 || ab0 !== 4'h0 || aopc0 !== 3'h0) $display("FAIL reset_alu: got %h %h %h want 0 0 0", aopc0, aa0, ab0); else pass_cnt++;
    total++; if (rd0 !== 4'h0 || rid0 !== 1'b0) $display("FAIL reset_rsp: got id %b data %h want 0 0", rid0, rd0); else pass_cnt++;
    v0 = 2'b00;
    rstn = 1'b1; rstn1 = 1'b1;
    tick;
  endtask

  task automatic test_single;
    v0 = 2'b01; opc0 = 6'b000_010; a0 = 8'h03; b0 = 8'h05; rr0 = 1'b1;
    #1;
    total++; if (rdy0 !== 2'b01) $display("FAIL single_grant: got %b want 01", rdy0); else pass_cnt++;
    tick;
    v0 = 2'b00;
    total++; if (rdy0 !== 2'b00) $display("FAIL single_ready_wait: got %b want 00", rdy0); else pass_cnt++;
    total++; if (busy0 !== 1'b1) $display("FAIL single_busy: got %b want 1", busy0); else pass_cnt++;
    total++; if (aopc0 !== 3'b010 || aa0 !== 4'h3 || ab0 !== 4'h5) $display("FAIL single_alu: got %b %h %h want 010 3 5", aopc0, aa0, ab0); else pass_cnt++;
    total++; if (rv0 !== 1'b0) $display("FAIL single_early_valid: got %b want 0", rv0); else pass_cnt++;
    tick;
    total++; if (rv0 !== 1'b1 || rid0 !== 1'b0 || rd0 !== 4'h8) $display("FAIL single_rsp: got v%b id%b d%h want v1 id0 d8", rv0, rid0, rd0); else pass_cnt++;
    tick;
    total++; if (rv0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL single_done: got v%b busy%b want v0 busy0", rv0, busy0); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic       g;
    logic [3:0] exp_d;
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    tick;
    a0 = 8'h71; b0 = 8'h42; opc0 = 6'b001_000; rr0 = 1'b1; v0 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp_d = g ? 4'hB : 4'h3;
      #1;
      total++; if (rdy0 !== (g ? 2'b10 : 2'b01)) $display("FAIL rr_grant%0d: got %b want %b", k, rdy0, g ? 2'b10 : 2'b01); else pass_cnt++;
      tick;
      tick;
      total++; if (rv0 !== 1'b1 || rid0 !== g || rd0 !== exp_d) $display("FAIL rr_rsp%0d: got v%b id%b d%h want v1 id%b d%h", k, rv0, rid0, rd0, g, exp_d); else pass_cnt++;
      tick;
    end
    v0 = 2'b00;
  endtask

  task automatic test_backpressure;
    v0 = 2'b01; a0 = 8'h09; b0 = 8'h09; rr0 = 1'b0;
    #1;
    total++; if (rdy0 !== 2'b01) $display("FAIL bp_grant: got %b want 01", rdy0); else pass_cnt++;
    tick;
    v0 = 2'b11;
    tick;
    for (int k = 0; k < 5; k++) begin
      total++; if (rv0 !== 1'b1 || rid0 !== 1'b0 || rd0 !== 4'h2) $display("FAIL bp_hold%0d: got v%b id%b d%h want v1 id0 d2", k, rv0, rid0, rd0); else pass_cnt++;
      total++; if (rdy0 !== 2'b00) $display("FAIL bp_ready%0d: got %b want 00", k, rdy0); else pass_cnt++;
      tick;
    end
    rr0 = 1'b1;
    #1;
    total++; if (rdy0 !== 2'b00 || rv0 !== 1'b1) $display("FAIL bp_hs_cycle: got rdy%b v%b want rdy00 v1", rdy0, rv0); else pass_cnt++;
    tick;
    total++; if (rv0 !== 1'b0) $display("FAIL bp_release: got %b want 0", rv0); else pass_cnt++;
    total++; if (rdy0 !== 2'b10) $display("FAIL bp_next_grant: got %b want 10", rdy0); else pass_cnt++;
    v0 = 2'b00;
    tick;
    total++; if (rv0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL bp_single_hs: got v%b busy%b want v0 busy0", rv0, busy0); else pass_cnt++;
  endtask

  task automatic test_withdrawn;
    v0 = 2'b01; a0 = 8'h0A; b0 = 8'h07; rr0 = 1'b0;
    #1;
    total++; if (rdy0 !== 2'b01) $display("FAIL wd_grant: got %b want 01", rdy0); else pass_cnt++;
    tick;
    v0 = 2'b10;
    #1;
    total++; if (rdy0 !== 2'b00) $display("FAIL wd_no_grant_wait: got %b want 00", rdy0); else pass_cnt++;
    tick;
    v0 = 2'b00;
    total++; if (rv0 !== 1'b1 || rid0 !== 1'b0 || rd0 !== 4'h1) $display("FAIL wd_rsp: got v%b id%b d%h want v1 id0 d1", rv0, rid0, rd0); else pass_cnt++;
    rr0 = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      total++; if (rv0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 2'b00) $display("FAIL wd_quiet%0d: got v%b busy%b rdy%b want 0 0 00", k, rv0, busy0, rdy0); else pass_cnt++;
      tick;
    end
  endtask

  task automatic test_reset_mid_op;
    rr1 = 1'b1; v1 = 2'b01; a1 = 8'h04; b1 = 8'h04; opc1 = 6'b101_000;
    #1;
    total++; if (rdy1 !== 2'b01) $display("FAIL rm_grant0: got %b want 01", rdy1); else pass_cnt++;
    tick;
    v1 = 2'b00;
    repeat (3) tick;
    total++; if (rv1 !== 1'b1 || rid1 !== 1'b0 || rd1 !== 4'h8) $display("FAIL rm_rsp0: got v%b id%b d%h want v1 id0 d8", rv1, rid1, rd1); else pass_cnt++;
    tick;
    v1 = 2'b10; a1 = 8'h54; b1 = 8'h34;
    #1;
    total++; if (rdy1 !== 2'b10) $display("FAIL rm_grant1: got %b want 10", rdy1); else pass_cnt++;
    tick;
    v1 = 2'b00;
    total++; if (busy1 !== 1'b1 || aa1 !== 4'h5 || aopc1 !== 3'b101) $display("FAIL rm_issue1: got busy%b op1 %h opc %b want 1 5 101", busy1, aa1, aopc1); else pass_cnt++;
    tick;
    rstn1 = 1'b0; v1 = 2'b11;
    #1;
    total++; if (aa1 !== 4'h0 || ab1 !== 4'h0 || aopc1 !== 3'h0) $display("FAIL rm_alu_clear: got %b %h %h want 0 0 0", aopc1, aa1, ab1); else pass_cnt++;
    total++; if (rv1 !== 1'b0 || rid1 !== 1'b0 || rd1 !== 4'h0) $display("FAIL rm_rsp_clear: got v%b id%b d%h want 0 0 0", rv1, rid1, rd1); else pass_cnt++;
    total++; if (busy1 !== 1'b0 || rdy1 !== 2'b00) $display("FAIL rm_busy_ready: got busy%b rdy%b want 0 00", busy1, rdy1); else pass_cnt++;
    @(negedge clk);
    rstn1 = 1'b1;
    #1;
    total++; if (rdy1 !== 2'b01) $display("FAIL rm_restart_prio: got %b want 01", rdy1); else pass_cnt++;
    @(posedge clk);
    #1;
    v1 = 2'b00;
    repeat (3) tick;
    total++; if (rv1 !== 1'b1 || rid1 !== 1'b0 || rd1 !== 4'h8) $display("FAIL rm_rsp_after: got v%b id%b d%h want v1 id0 d8", rv1, rid1, rd1); else pass_cnt++;
    tick;
  endtask

  task automatic test_wrap;
    rr2 = 1'b1; v2 = 3'b100; a2 = 12'h600; b2 = 12'h700; opc2 = 9'b011_000_000;
    #1;
    total++; if (rdy2 !== 3'b100) $display("FAIL wrap_grant2: got %b want 100", rdy2); else pass_cnt++;
    tick;
    acc1 = cyc;
    v2 = 3'b001; a2 = 12'h601; b2 = 12'h702;
    #1;
    total++; if (rdy2 !== 3'b000) $display("FAIL wrap_wait_ready: got %b want 000", rdy2); else pass_cnt++;
    tick;
    tick;
    total++; if (rv2 !== 1'b1 || rid2 !== 2'd2 || rd2 !== 4'hD) $display("FAIL wrap_rsp2: got v%b id%0d d%h want v1 id2 dD", rv2, rid2, rd2); else pass_cnt++;
    total++; if (rdy2 !== 3'b000) $display("FAIL wrap_resp_ready: got %b want 000", rdy2); else pass_cnt++;
    for (int k = 0; k < 10 && rdy2 !== 3'b001; k++) tick;
    tick;
    acc2 = cyc;
    v2 = 3'b000;
    total++; if (acc2 - acc1 != 4) $display("FAIL wrap_interval: got %0d want 4", acc2 - acc1); else pass_cnt++;
    total++; if (aa2 !== 4'h1 || ab2 !== 4'h2) $display("FAIL wrap_alu0: got %h %h want 1 2", aa2, ab2); else pass_cnt++;
    tick;
    tick;
    total++; if (rv2 !== 1'b1 || rid2 !== 2'd0 || rd2 !== 4'h3) $display("FAIL wrap_rsp0: got v%b id%0d d%h want v1 id0 d3", rv2, rid2, rd2); else pass_cnt++;
    tick;
    total++; if (rv2 !== 1'b0) $display("FAIL wrap_done: got %b want 0", rv2); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_withdrawn;
    test_reset_mid_op;
    test_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
